// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Watches a multiplexed 4-digit 7-segment display bus and turns it back
// into the 16-bit value being shown. Each digit dwell must be stable for
// STABLE_CYC samples before it is captured. Captured patterns are decoded
// to hex nibbles, and a frame is published once all four digits are seen.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low reset
//   a..g         segment levels, active-high (a top, g middle)
//   sel[3:0]     one-hot digit select, sel[0] = least-significant nibble
//   value[15:0]  last complete frame
//   value_valid  one-cycle pulse when value is updated
//   frame_err    set when the published frame contained an illegal pattern
module seg7_scan_reader #(
   parameter int STABLE_CYC = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   input  logic        e,
   input  logic        f,
   input  logic        g,
   input  logic [3:0]  sel,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        frame_err
);

   localparam logic [7:0] CAP_AT = 8'(STABLE_CYC - 1);

   logic [10:0] sample;
   logic [10:0] sample_q;
   logic [7:0]  cnt;
   logic [7:0]  cnt_next;
   logic        cap_flag;
   logic        cap_flag_next;
   logic        changed;
   logic        capture;

   logic        one_hot;
   logic [1:0]  dig_idx;
   logic [3:0]  dig_bit;
   logic [3:0]  nibble;
   logic        illegal;

   logic [15:0] shadow;
   logic [15:0] shadow_upd;
   logic [3:0]  mask;
   logic [3:0]  mask_upd;
   logic        err_acc;
   logic        err_upd;

   assign sample  = {sel, a, b, c, d, e, f, g};
   assign changed = (sample != sample_q);

   // Dwell tracking: the counter is compared against the incoming sample,
   // so the edge that registers a new value is already count 0. The capture
   // flag stops a long dwell (including a saturated counter) from being
   // captured twice.
   always_comb begin
      cnt_next      = 8'd0;
      cap_flag_next = 1'b0;
      if (!changed) begin
         cnt_next      = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
         cap_flag_next = cap_flag;
      end
      capture = (cnt_next == CAP_AT) && one_hot && !cap_flag_next;
      if (capture) begin
         cap_flag_next = 1'b1;
      end
   end

   // Turn the one-hot select into a digit index; blank or multi-hot
   // selects are flagged as not capturable.
   always_comb begin
      one_hot = 1'b1;
      dig_idx = 2'd0;
      case (sample[10:7])
         4'b0001: dig_idx = 2'd0;
         4'b0010: dig_idx = 2'd1;
         4'b0100: dig_idx = 2'd2;
         4'b1000: dig_idx = 2'd3;
         default: one_hot = 1'b0;
      endcase
      dig_bit = 4'b0001 << dig_idx;
   end

   // Segment pattern {a..g} back to its hex nibble; anything not in the
   // table reads as 0 and marks the frame as erroneous.
   always_comb begin
      nibble  = 4'h0;
      illegal = 1'b0;
      case (sample[6:0])
         7'b1111110: nibble = 4'h0;
         7'b0110000: nibble = 4'h1;
         7'b1101101: nibble = 4'h2;
         7'b1111001: nibble = 4'h3;
         7'b0110011: nibble = 4'h4;
         7'b1011011: nibble = 4'h5;
         7'b1011111: nibble = 4'h6;
         7'b1110000: nibble = 4'h7;
         7'b1111111: nibble = 4'h8;
         7'b1111011: nibble = 4'h9;
         7'b1110111: nibble = 4'hA;
         7'b0011111: nibble = 4'hB;
         7'b1001110: nibble = 4'hC;
         7'b0111101: nibble = 4'hD;
         7'b1001111: nibble = 4'hE;
         7'b1000111: nibble = 4'hF;
         default:    illegal = 1'b1;
      endcase
   end

   // Frame assembly: a digit seen twice before the frame closes means the
   // scan restarted, so the partial frame collapses to just this digit.
   always_comb begin
      shadow_upd = shadow;
      shadow_upd[{dig_idx, 2'b00} +: 4] = nibble;
      if (mask[dig_idx]) begin
         mask_upd = dig_bit;
         err_upd  = illegal;
      end else begin
         mask_upd = mask | dig_bit;
         err_upd  = err_acc | illegal;
      end
   end

   // State registers; a completed frame publishes on the same edge as the
   // capture that completed it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_q    <= '0;
         cnt         <= '0;
         cap_flag    <= 1'b0;
         shadow      <= '0;
         mask        <= '0;
         err_acc     <= 1'b0;
         value       <= '0;
         value_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         sample_q    <= sample;
         cnt         <= cnt_next;
         cap_flag    <= cap_flag_next;
         value_valid <= 1'b0;
         if (capture) begin
            shadow <= shadow_upd;
            if (mask_upd == 4'hF) begin
               value       <= shadow_upd;
               frame_err   <= err_upd;
               value_valid <= 1'b1;
               mask        <= '0;
               err_acc     <= 1'b0;
            end else begin
               mask    <= mask_upd;
               err_acc <= err_upd;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader
// Self-checking bench for seg7_scan_reader. A behavioural model tracks
// run lengths of driven samples and assembles frames from the segment
// table; a compare process checks the DUT against it every cycle, and
// directed scenarios pin the results with hand-computed values.
module tb_seg7_scan_reader;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  seg = 7'd0;
   logic [3:0]  sel = 4'd0;
   logic [15:0] value;
   logic        value_valid;
   logic        frame_err;

   int checks = 0;
   int failures = 0;
   int dutPulses = 0;
   bit started = 1'b0;

   logic [6:0] segTable [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   seg7_scan_reader #(.STABLE_CYC(STABLE)) dut (
      .clk(clk), .reset(reset),
      .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]),
      .e(seg[2]), .f(seg[1]), .g(seg[0]),
      .sel(sel), .value(value), .value_valid(value_valid),
      .frame_err(frame_err));

   always #5 clk = ~clk;

   // Behavioural model: a digit is taken when its run of identical samples
   // reaches STABLE long; a frame closes once all four digits have been seen.
   logic [10:0] prevSample;
   int          runLen;
   bit          seen [4];
   logic [3:0]  nib [4];
   bit          mErr;
   logic [15:0] expValue;
   bit          expValid;
   bit          expErr;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         prevSample = '0;
         runLen     = 1;
         mErr       = 0;
         expValue   = '0;
         expValid   = 0;
         expErr     = 0;
         for (int i = 0; i < 4; i++) begin
            seen[i] = 0;
            nib[i]  = 4'h0;
         end
      end else begin
         logic [10:0] s;
         int idx;
         int n;
         bit bad;
         bit all;
         s = {sel, seg};
         if (s == prevSample) runLen++;
         else runLen = 1;
         prevSample = s;
         expValid = 0;
         if (runLen == STABLE && $countones(sel) == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            n = 0;
            bad = 1;
            for (int k = 0; k < 16; k++) begin
               if (segTable[k] == seg) begin
                  n = k;
                  bad = 0;
               end
            end
            if (seen[idx]) begin
               for (int i = 0; i < 4; i++) seen[i] = 0;
               mErr = 0;
            end
            seen[idx] = 1;
            nib[idx]  = 4'(n);
            mErr      = mErr | bad;
            all = seen[0] && seen[1] && seen[2] && seen[3];
            if (all) begin
               expValue = {nib[3], nib[2], nib[1], nib[0]};
               expErr   = mErr;
               expValid = 1;
               mErr     = 0;
               for (int i = 0; i < 4; i++) seen[i] = 0;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         checks += 3;
         if (value !== expValue) begin
            failures++;
            $display("[TB] FAIL cyc_value actual=%h required=%h t=%0t", value, expValue, $time);
         end
         if (value_valid !== expValid) begin
            failures++;
            $display("[TB] FAIL cyc_valid actual=%b required=%b t=%0t", value_valid, expValid, $time);
         end
         if (frame_err !== expErr) begin
            failures++;
            $display("[TB] FAIL cyc_err actual=%b required=%b t=%0t", frame_err, expErr, $time);
         end
         if (value_valid === 1'b1) dutPulses++;
      end
   end

   // Drive one dwell of a digit/pattern for n cycles, starting at a negedge.
   task automatic applyStimulus(input logic [3:0] s, input logic [6:0] p, input int n);
      sel = s;
      seg = p;
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
      end
   endtask

   int p0;

   initial begin
      repeat (3) @(negedge clk);
      started = 1'b1;
      checkOutput("rst_value", 32'(value), 32'h0);
      checkOutput("rst_valid", 32'(value_valid), 32'h0);
      checkOutput("rst_err", 32'(frame_err), 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Basic frame 4,3,2,1 on digits 0..3
      p0 = dutPulses;
      applyStimulus(4'b0001, segTable[4], 10);
      applyStimulus(4'b0010, segTable[3], 10);
      applyStimulus(4'b0100, segTable[2], 10);
      applyStimulus(4'b1000, segTable[1], 10);
      checkOutput("t1_value", 32'(value), 32'h1234);
      checkOutput("t1_model", 32'(expValue), 32'h1234);
      checkOutput("t1_err", 32'(frame_err), 32'h0);
      checkOutput("t1_pulses", 32'(dutPulses - p0), 32'd1);

      // Order 3,1,0,2 with a saturating dwell and blanking in between
      p0 = dutPulses;
      applyStimulus(4'b1000, segTable[15], 300);
      applyStimulus(4'b0000, 7'd0, 3);
      applyStimulus(4'b0010, segTable[11], 10);
      applyStimulus(4'b0011, segTable[8], 6);
      applyStimulus(4'b0001, segTable[0], 10);
      applyStimulus(4'b0000, 7'd0, 2);
      checkOutput("t2_nopulse", 32'(dutPulses - p0), 32'd0);
      applyStimulus(4'b0100, segTable[14], 10);
      checkOutput("t2_value", 32'(value), 32'hFEB0);
      checkOutput("t2_pulses", 32'(dutPulses - p0), 32'd1);

      // Illegal pattern on digit 1, then a clean frame
      applyStimulus(4'b0001, segTable[0], 8);
      applyStimulus(4'b0010, 7'b0000001, 8);
      applyStimulus(4'b0100, segTable[0], 8);
      applyStimulus(4'b1000, segTable[0], 8);
      checkOutput("t3_value", 32'(value), 32'h0000);
      checkOutput("t3_err", 32'(frame_err), 32'h1);
      applyStimulus(4'b0001, segTable[5], 8);
      applyStimulus(4'b0010, segTable[6], 8);
      applyStimulus(4'b0100, segTable[7], 8);
      applyStimulus(4'b1000, segTable[8], 8);
      checkOutput("t3_clean_value", 32'(value), 32'h8765);
      checkOutput("t3_clean_err", 32'(frame_err), 32'h0);

      // Glitch: a 3-cycle digit-2 dwell must be ignored
      p0 = dutPulses;
      applyStimulus(4'b0001, segTable[9], 8);
      applyStimulus(4'b0010, segTable[10], 8);
      applyStimulus(4'b0100, segTable[12], 3);
      applyStimulus(4'b1000, segTable[13], 8);
      checkOutput("t4_nopulse", 32'(dutPulses - p0), 32'd0);
      applyStimulus(4'b0100, segTable[12], 5);
      checkOutput("t4_value", 32'(value), 32'hDCA9);
      checkOutput("t4_model", 32'(expValue), 32'hDCA9);
      checkOutput("t4_pulses", 32'(dutPulses - p0), 32'd1);

      // Repeat: 0,1,0,1,2,3 restarts on the second digit 0
      p0 = dutPulses;
      applyStimulus(4'b0001, segTable[1], 6);
      applyStimulus(4'b0010, segTable[2], 6);
      applyStimulus(4'b0001, segTable[3], 6);
      applyStimulus(4'b0010, segTable[4], 6);
      applyStimulus(4'b0100, segTable[5], 6);
      applyStimulus(4'b1000, segTable[6], 6);
      checkOutput("t5_value", 32'(value), 32'h6543);
      checkOutput("t5_pulses", 32'(dutPulses - p0), 32'd1);

      // Asynchronous reset after three captured digits
      applyStimulus(4'b0001, segTable[7], 6);
      applyStimulus(4'b0010, segTable[7], 6);
      applyStimulus(4'b0100, segTable[7], 6);
      #2;
      reset = 1'b0;
      sel = 4'b0000;
      seg = 7'd0;
      #1;
      checkOutput("t6_rst_value", 32'(value), 32'h0);
      checkOutput("t6_rst_valid", 32'(value_valid), 32'h0);
      checkOutput("t6_rst_err", 32'(frame_err), 32'h0);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      @(negedge clk);
      p0 = dutPulses;
      applyStimulus(4'b1000, segTable[8], 8);
      checkOutput("t6_nopulse", 32'(dutPulses - p0), 32'd0);
      applyStimulus(4'b0001, segTable[10], 8);
      applyStimulus(4'b0010, segTable[11], 8);
      applyStimulus(4'b0100, segTable[12], 8);
      checkOutput("t6_value", 32'(value), 32'h8CBA);
      checkOutput("t6_pulses", 32'(dutPulses - p0), 32'd1);

      applyStimulus(4'b0000, 7'd0, 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the team's 7-segment digit decoder. Monitors a multiplexed 4-digit common-select display bus (segments a–g plus one-hot digit select), debounces each digit dwell, decodes every segment pattern back into its hex nibble, and publishes the reassembled 16-bit value once per complete scan frame. Used to self-check the display path and to loop displayed values back into the CPU test harness.

## Interface
Parameters:
- `STABLE_CYC`, default 4: number of consecutive identical input samples required before a digit is captured; legal range 1..255.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately, independent of `clk`.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`  in  1 each  segment levels, active-high, standard lettering (a top, g middle).
- `sel`  in  4  digit select, active-high one-hot; `sel[i]` selects digit i, where digit 0 is the least-significant nibble.
- `value`  out  16  last complete frame; digit i occupies `value[4*i+3:4*i]`.
- `value_valid`  out  1  one-cycle pulse when `value` is updated.
- `frame_err`  out  1  qualified by `value_valid`; 1 = at least one digit in the frame had an illegal pattern.

## Operation
- Segment vector order is `{a,b,c,d,e,f,g}`. Legal patterns, digits 0..F:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Any other pattern is illegal: it decodes to nibble 0 and sets the frame error flag.
- Input stage: `{sel, a..g}` is registered every cycle.
- Stability counter:
  - Saturating, 8 bits.
  - Clears to 0 when the new sample differs from the previous registered sample; otherwise increments.
  - A "dwell" is a run of identical samples.
- Capture: occurs exactly once per dwell, when the counter reaches `STABLE_CYC-1` and `sel` is one-hot. A per-dwell capture flag prevents re-capture and is cleared on any sample change.
- Blanking: `sel` = 0000 or multi-hot is never captured. It does not disturb frame state.
- Frame assembly (internal state: shadow register, 4-bit mask, error flag). On a capture of digit i:
  - Bit i not yet in the mask: write the nibble to shadow digit i and set mask bit i.
  - Bit i already set (digit repeated before the frame completed): start a new frame. Mask becomes only bit i, the error flag takes only this digit's legality, and shadow digit i is written.
  - Mask becomes 1111 after the capture: `value` is loaded from the shadow (including the nibble just captured), `frame_err` is loaded from the accumulated flag, and `value_valid` is set. Mask and flag then clear.
- Digit order within a frame is arbitrary; frame completion requires all four digits.
- `value` and `frame_err` hold until the next completed frame.

## Timing
- Reset values:
  - Outputs: `value`=0000, `value_valid`=0, `frame_err`=0.
  - Internal: mask=0, error flag=0, counter=0, capture flag=0, input register=all zero.
  - Reset asserted mid-frame discards the partial frame. Frame collection restarts only after reset is released.
- Latency: let edge T be the first edge that registers a new input. If the input is held, the capture happens at edge T+STABLE_CYC−1. If that capture completes the frame, `value`, `frame_err` and `value_valid` are updated at that same edge.
- `value_valid` is high for exactly one cycle. It is never asserted in two consecutive cycles when `STABLE_CYC` ≥ 2.
- `STABLE_CYC`=1: every changed sample with one-hot `sel` is captured at its first registered edge.
- A dwell shorter than `STABLE_CYC` samples (a glitch) produces no capture and no state change beyond resetting the counter.
- Counter saturation at 255 must not re-trigger capture.

## Test plan
- `STABLE_CYC`=4. Drive digits 0..3 with patterns for 4,3,2,1 (0110011, 1111001, 1101101, 0110000), 10 cycles each -> one `value_valid` pulse, `value`=16'h1234, `frame_err`=0; no other pulses.
- Scan order 3,1,0,2 with nibbles F,b,0,E -> `value`=16'hFEb0 (digit3=F, digit2=E, digit1=b, digit0=0), single pulse on the digit-2 capture.
- Digit 1 pattern 0000001 (illegal), other digits 0 -> `value`=16'h0000, `frame_err`=1; the next clean frame reports `frame_err`=0.
- Glitch: 3-cycle dwell of digit 2 inside an otherwise valid frame -> that dwell is ignored; the frame completes only after a ≥4-cycle digit-2 dwell.
- Repeat: digits 0,1,0,1,2,3 -> the second digit-0 capture restarts the frame; exactly one pulse, with the later digit-0/digit-1 nibbles.
- Assert `reset` asynchronously (between clock edges) after three digits are captured, then release -> outputs are 0 at once; one further digit produces no pulse; a full four-digit frame is required afterwards.
